// File: rtl/m_table_builder.sv
// m_table_builder: fills a reciprocal table, entry d = ceil(2^W / d) saturated
// to W bits, entry 0 = all-ones. One restoring division per entry, one quotient
// bit per cycle. The sticky divide-by-zero debug flag exists only when the
// macro M_TABLE_BUILDER_DBG_EN is defined; otherwise it is tied to 0.
module m_table_builder #(
    parameter int unsigned BUFFER_DEPTH  = 2048,
    parameter int unsigned M_TABLE_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            wr_en_o,
    output logic [$clog2(BUFFER_DEPTH)-1:0] wr_addr_o,
    output logic [M_TABLE_WIDTH-1:0]        wr_data_o,
    input  logic                            clear_debug_DIV_BY_ZERO_i,
    output logic                            debug_DIV_BY_ZERO_o
);

    localparam int unsigned W  = M_TABLE_WIDTH;
    localparam int unsigned AW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [AW-1:0] LAST_D = AW'(BUFFER_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        LOAD,
        DIV,
        WRITE,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] d_q, d_d;       // current divisor, doubles as write address
    logic [AW-1:0] rem_q, rem_d;   // partial remainder, always < d
    logic [W:0]    quo_q, quo_d;   // dividend shifted out, quotient shifted in
    logic [CW-1:0] cnt_q, cnt_d;   // quotient bits produced so far

    logic [AW:0]   trial;
    logic [AW-1:0] diff;
    logic [W:0]    dividend;

    // Next-state, datapath and strobe decode
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        wr_en_o  = 1'b0;
        trial    = {rem_q, quo_q[W]};
        // trial >= d implies trial - d < d, so the low AW bits hold the result
        diff     = trial[AW-1:0] - d_q;
        dividend = '0;
        dividend[W] = 1'b1;
        dividend[AW-1:0] = d_q - AW'(1);

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = ZERO;
                    d_d     = '0;
                end
            end
            ZERO: begin
                wr_en_o = 1'b1;
                d_d     = AW'(1);
                state_d = LOAD;
            end
            LOAD: begin
                rem_d   = '0;
                quo_d   = dividend;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                if (trial >= {1'b0, d_q}) begin
                    rem_d = diff;
                    quo_d = {quo_q[W-1:0], 1'b1};
                end else begin
                    rem_d = trial[AW-1:0];
                    quo_d = {quo_q[W-1:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_en_o = 1'b1;
                if (d_q == LAST_D) begin
                    state_d = FIN;
                end else begin
                    d_d     = d_q + AW'(1);
                    state_d = LOAD;
                end
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_addr_o = d_q;
    // Quotient bit W is set only for d = 1 (2^W); clamp it rather than wrap to 0
    assign wr_data_o = (state_q == ZERO) ? '1 :
                       (quo_q[W] ? '1 : quo_q[W-1:0]);

`ifdef M_TABLE_BUILDER_DBG_EN
    logic dbg_q, dbg_d;

    // Sticky flag: set after the entry-0 write, set wins over a same-cycle clear
    always_comb begin
        dbg_d = dbg_q;
        if (clear_debug_DIV_BY_ZERO_i) begin
            dbg_d = 1'b0;
        end
        if (state_q == ZERO) begin
            dbg_d = 1'b1;
        end
    end

    // Flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbg_q <= 1'b0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign debug_DIV_BY_ZERO_o = dbg_q;
`else
    logic unused_clear_dbg;
    assign unused_clear_dbg    = clear_debug_DIV_BY_ZERO_i;
    assign debug_DIV_BY_ZERO_o = 1'b0;
`endif

endmodule

// File: tb/tb_m_table_builder.sv
// Self-checking bench for m_table_builder (W=32, 2048 entries). Expected table
// entries are pushed to a scoreboard queue when start is driven and popped as
// writes are captured. Build with M_TABLE_BUILDER_DBG_EN to exercise the flag.
module tb_m_table_builder;

    localparam int DEPTH = 2048;

`ifdef M_TABLE_BUILDER_DBG_EN
    localparam logic DBG_EXP = 1'b1;
`else
    localparam logic DBG_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        busy_o, done_o, wr_en_o, debug_o;
    logic [10:0] wr_addr_o;
    logic [31:0] wr_data_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    wr_t         exp_q[$];
    logic [10:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_edge[$];

    m_table_builder #(
        .BUFFER_DEPTH (DEPTH),
        .M_TABLE_WIDTH(32)
    ) dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_ni),
        .start_i                  (start_i),
        .busy_o                   (busy_o),
        .done_o                   (done_o),
        .wr_en_o                  (wr_en_o),
        .wr_addr_o                (wr_addr_o),
        .wr_data_o                (wr_data_o),
        .clear_debug_DIV_BY_ZERO_i(clear_i),
        .debug_DIV_BY_ZERO_o      (debug_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_expected();
        for (int d = 0; d < DEPTH; d++) begin
            logic [63:0] q;
            if (d == 0) begin
                q = 64'hFFFF_FFFF;
            end else begin
                q = (64'h1_0000_0000 + 64'(d) - 64'd1) / 64'(d);
                if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
            end
            exp_q.push_back('{addr: 11'(d), data: q[31:0]});
        end
    endtask

    // Drives a start pulse that the DUT samples at edge k
    task automatic do_start(output int k);
        @(negedge clk);
        start_i = 1'b1;
        k = cyc + 1;
        push_expected();
    endtask

    // Records writes (no checking) until done, a stop address, or the budget
    task automatic capture(input int stop_after_addr, input int restart_addr,
                           input bit hold_clear, input int max_cycles,
                           output int done_edge, output bit timed_out,
                           output int busy_gaps, output int dbg_bad,
                           output logic dbg_after_set);
        bit fin;
        cap_addr.delete();
        cap_data.delete();
        cap_edge.delete();
        done_edge = -1;
        timed_out = 1'b1;
        busy_gaps = 0;
        dbg_bad = 0;
        dbg_after_set = 1'b0;
        fin = 1'b0;
        for (int n = 0; n < max_cycles && !fin; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o !== 1'b1) busy_gaps++;
`ifndef M_TABLE_BUILDER_DBG_EN
            if (debug_o !== 1'b0) dbg_bad++;
`endif
            if (wr_en_o === 1'b1) begin
                cap_addr.push_back(wr_addr_o);
                cap_data.push_back(wr_data_o);
                cap_edge.push_back(cyc + 1);
                if (restart_addr >= 0 && int'(wr_addr_o) == restart_addr)
                    start_i = 1'b1;
                if (stop_after_addr >= 0 && int'(wr_addr_o) == stop_after_addr) begin
                    timed_out = 1'b0;
                    fin = 1'b1;
                end else if (hold_clear && wr_addr_o == 11'd0) begin
                    @(posedge clk);
                    #1;
                    clear_i = 1'b0;
                    dbg_after_set = debug_o;
                end
            end
            if (!fin && done_o === 1'b1) begin
                done_edge = cyc + 1;
                timed_out = 1'b0;
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en_o); end
        checks++; if (wr_addr_o !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h expected 000", wr_addr_o); end
        checks++; if (wr_data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", wr_data_o); end
        checks++; if (debug_o !== 1'b0) begin errors++; $display("FAIL reset_dbg: got %b expected 0", debug_o); end
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b wr_en %b expected 0 0", busy_o, wr_en_o); end
    endtask

    // Build aborted by reset while entry 500 is being divided
    task automatic test_mid_build_reset();
        int k, done_edge, busy_gaps, dbg_bad;
        bit to;
        logic das;
        do_start(k);
        capture(499, -1, 1'b0, 20000, done_edge, to, busy_gaps, dbg_bad, das);
        checks++; if (to) begin errors++; $display("FAIL partial_timeout: entry 499 not written within budget"); end
        checks++; if (cap_addr.size() != 500) begin errors++; $display("FAIL partial_count: got %0d expected 500", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size(); i++) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL partial_sb: extra write addr %h", cap_addr[i]);
            end else begin
                e = exp_q.pop_front();
                if (cap_addr[i] !== e.addr || cap_data[i] !== e.data) begin
                    errors++;
                    $display("FAIL partial_entry: got addr %h data %h expected addr %h data %h", cap_addr[i], cap_data[i], e.addr, e.data);
                end
            end
        end
        checks++; if (debug_o !== DBG_EXP) begin errors++; $display("FAIL dbg_set: got %b expected %b", debug_o, DBG_EXP); end
        clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        checks++; if (debug_o !== 1'b0) begin errors++; $display("FAIL dbg_clear: got %b expected 0", debug_o); end
        repeat (5) @(posedge clk);
        #2;
        checks++; if (busy_o !== 1'b1 || wr_en_o !== 1'b0) begin errors++; $display("FAIL pre_reset_div: busy %b wr_en %b expected 1 0", busy_o, wr_en_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy_o); end
        checks++; if (wr_en_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL async_strobes: wr_en %b done %b expected 0 0", wr_en_o, done_o); end
        checks++; if (wr_addr_o !== 11'd0) begin errors++; $display("FAIL async_addr: got %h expected 000", wr_addr_o); end
        checks++; if (wr_data_o !== 32'd0) begin errors++; $display("FAIL async_data: got %h expected 00000000", wr_data_o); end
        checks++; if (debug_o !== 1'b0) begin errors++; $display("FAIL async_dbg: got %b expected 0", debug_o); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin errors++; $display("FAIL idle_after_midreset: busy %b wr_en %b expected 0 0", busy_o, wr_en_o); end
    endtask

    // Full build with start re-pulsed at entry 100 and clear held over entry 0
    task automatic test_full_build();
        int k, done_edge, busy_gaps, dbg_bad, last_edge;
        bit to;
        logic das;
        int          spot_a[7];
        logic [31:0] spot_d[7];
        spot_a = '{0, 1, 2, 3, 4, 5, 2047};
        spot_d = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h55555556,
                   32'h40000000, 32'h33333334, 32'h00200401};
        clear_i = 1'b1;
        do_start(k);
        capture(-1, 100, 1'b1, 75000, done_edge, to, busy_gaps, dbg_bad, das);
        checks++; if (to) begin errors++; $display("FAIL full_timeout: done_o not seen within budget"); end
        checks++; if (cap_addr.size() != DEPTH) begin errors++; $display("FAIL write_count: got %0d expected %0d", cap_addr.size(), DEPTH); end
        for (int i = 0; i < cap_addr.size(); i++) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL full_sb: extra write addr %h", cap_addr[i]);
            end else begin
                e = exp_q.pop_front();
                if (cap_addr[i] !== e.addr || cap_data[i] !== e.data) begin
                    errors++;
                    $display("FAIL full_entry: got addr %h data %h expected addr %h data %h", cap_addr[i], cap_data[i], e.addr, e.data);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d unwritten entries expected 0", exp_q.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (spot_a[i] >= cap_data.size()) begin
                errors++; $display("FAIL spot_%0d: entry missing expected %h", spot_a[i], spot_d[i]);
            end else if (cap_data[spot_a[i]] !== spot_d[i]) begin
                errors++; $display("FAIL spot_%0d: got %h expected %h", spot_a[i], cap_data[spot_a[i]], spot_d[i]);
            end
        end
        if (cap_edge.size() >= 2) begin
            checks++; if (cap_edge[0] - k != 1) begin errors++; $display("FAIL first_write_lat: got %0d expected 1", cap_edge[0] - k); end
            checks++; if (cap_edge[1] - cap_edge[0] != 35) begin errors++; $display("FAIL write_spacing: got %0d expected 35", cap_edge[1] - cap_edge[0]); end
            last_edge = cap_edge[cap_edge.size() - 1];
        end else begin
            last_edge = -1;
        end
        checks++; if (last_edge - k != 71646) begin errors++; $display("FAIL last_write_lat: got %0d expected 71646", last_edge - k); end
        checks++; if (done_edge - k != 71647) begin errors++; $display("FAIL done_lat: got %0d expected 71647", done_edge - k); end
        checks++; if (busy_gaps != 0) begin errors++; $display("FAIL busy_gaps: got %0d expected 0", busy_gaps); end
        checks++; if (das !== DBG_EXP) begin errors++; $display("FAIL dbg_set_wins: got %b expected %b", das, DBG_EXP); end
`ifndef M_TABLE_BUILDER_DBG_EN
        checks++; if (dbg_bad != 0) begin errors++; $display("FAIL dbg_tied_low: got %0d nonzero samples expected 0", dbg_bad); end
`endif
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL post_done: busy %b done %b expected 0 0", busy_o, done_o); end
        repeat (10) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin errors++; $display("FAIL no_queued_start: busy %b wr_en %b expected 0 0", busy_o, wr_en_o); end
    endtask

    initial begin
        test_reset();
        test_mid_build_reset();
        test_full_build();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_table_builder.md
M_TABLE_BUILDER -- requirements
Module: m_table_builder

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 2048, giving the number of table entries and the divisor range 0..BUFFER_DEPTH-1.
REQ-002 SHALL have parameter M_TABLE_WIDTH, default 32, giving the entry width W.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: a one-cycle request to rebuild the full table.
REQ-006 SHALL have port busy_o, output, 1 bit: high while a build is in progress.
REQ-007 SHALL have port done_o, output, 1 bit: a one-cycle pulse at the end of a build.
REQ-008 SHALL have port wr_en_o, output, 1 bit: the table RAM write strobe.
REQ-009 SHALL have port wr_addr_o, output, $clog2(BUFFER_DEPTH) bits: the table RAM write address.
REQ-010 SHALL have port wr_data_o, output, M_TABLE_WIDTH bits: the table RAM write data.
REQ-011 SHALL have port clear_debug_DIV_BY_ZERO_i, input, 1 bit: clears the sticky divide-by-zero flag.
REQ-012 SHALL have port debug_DIV_BY_ZERO_o, output, 1 bit: the sticky divide-by-zero flag.

Function
REQ-013 SHALL write entry d = ceil(2^W / d) for d = 1..BUFFER_DEPTH-1, saturated to 2^W-1 when the result does not fit in W bits (d = 1).
REQ-014 SHALL write entry 0 = all-ones (2^W-1), because divisor 0 is undefined.
REQ-015 SHALL compute each entry by sequential restoring division of (2^W + d - 1) by d, producing one quotient bit per cycle over W+1 cycles.
REQ-016 SHALL use an FSM with states IDLE, ZERO, LOAD, DIV, WRITE and FIN.
REQ-017 SHALL move IDLE->ZERO when start_i is sampled high in IDLE; ZERO asserts the entry-0 write for exactly one cycle.
REQ-018 SHALL move ZERO->LOAD with d = 1; LOAD initialises the remainder and quotient in 1 cycle.
REQ-019 SHALL hold DIV for exactly W+1 cycles and then move to WRITE.
REQ-020 SHALL assert wr_en_o for exactly one cycle in WRITE, then go to LOAD with d+1, or to FIN when d = BUFFER_DEPTH-1.
REQ-021 SHALL pulse done_o for one cycle in FIN and return to IDLE on the next cycle.
REQ-022 Timing: with start_i sampled at edge k, the entry-0 write SHALL occur in cycle k+1, each later write W+3 cycles after the previous one, and done_o one cycle after the last write; busy_o SHALL be high from cycle k+1 through the done_o cycle.
REQ-023 Outside write cycles, wr_addr_o and wr_data_o SHALL be don't-care, and wr_en_o SHALL be 0.
REQ-024 SHALL ignore start_i while busy_o is high; no restart and no queuing.
REQ-025 SHALL apply the quotient saturation before the write, so wr_data_o never wraps to 0.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE and set busy_o=0, done_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0 and debug_DIV_BY_ZERO_o=0, including in the middle of a build.
REQ-027 After a mid-build reset, a new start_i SHALL restart the build from entry 0; the partially written table SHALL NOT be resumed.

Configuration
REQ-028 With macro M_TABLE_BUILDER_DBG_EN defined, debug_DIV_BY_ZERO_o SHALL be set in the cycle after the entry-0 write and SHALL stay set until clear_debug_DIV_BY_ZERO_i is high at a clock edge.
REQ-029 When the set and clear events occur in the same cycle, set SHALL win.
REQ-030 Without M_TABLE_BUILDER_DBG_EN, debug_DIV_BY_ZERO_o SHALL be constant 0, clear_debug_DIV_BY_ZERO_i SHALL be ignored, and no flag register SHALL be inferred.

Verification
REQ-031 Bench SHALL cover: reset, then a start_i pulse -> writes at addr 0 = FFFFFFFF, 1 = FFFFFFFF, 2 = 80000000, 3 = 55555556, 4 = 40000000, 5 = 33333334, 2047 = 00200401 (W=32).
REQ-032 Bench SHALL cover: build timing -> exactly 2048 wr_en_o pulses; the last write 71646 cycles after the start edge; done_o at 71647; busy_o low afterwards.
REQ-033 Bench SHALL cover: start_i re-pulsed at the entry-100 write -> no disturbance, write count still 2048, identical data.
REQ-034 Bench SHALL cover: rst_ni low during the DIV state of entry 500 -> all outputs 0 asynchronously, state IDLE; a new start -> a full correct table from addr 0.
REQ-035 Bench SHALL cover, with M_TABLE_BUILDER_DBG_EN: flag = 1 after the entry-0 write; a clear pulse -> 0; clear held through the entry-0 write -> flag = 1.
REQ-036 Bench SHALL cover, without M_TABLE_BUILDER_DBG_EN: debug_DIV_BY_ZERO_o = 0 throughout the full build.
